unsadd_run_ctrl: RTL and testbench
==================================

// Module: unsadd_run_ctrl
// PURPOSE
//  Run controller for the 16-input unipolar non-scaled stochastic adder (uNSADD16) and its input SNGs.
//  Accepts one job at a time (stream length + lane mask) and holds the adder cleared between jobs.
//  Per job: pulses SNG load, enables the streams for exactly L cycles, then counts adder-output ones over L samples.
//  Returns the count via a valid/ready result port. Sits between the job dispatcher and one adder instance.
// PARAMETERS
//  N      16  number of adder input lanes (width of lane mask)
//  LEN_W  12  width of stream length and ones count; max job length 2**LEN_W-1 cycles
// PORTS
//  clk          in   1      clock
//  rst          in   1      synchronous reset, active-high
//  start_valid  in   1      job request
//  start_ready  out  1      controller can accept a job (IDLE only)
//  cfg_len      in   LEN_W  stream length L in cycles; sampled on start handshake
//  cfg_mask     in   N      lane enable mask; sampled on start handshake
//  abort        in   1      terminate current run early
//  sng_load     out  1      1-cycle pulse: SNGs load seeds/operands
//  sng_en       out  1      SNG stream enable
//  lane_mask    out  N      registered job mask; gates adder inputs
//  add_clr      out  1      adder clear, driven from a flop; adder rst_n = ~add_clr
//  add_out      in   1      adder output bitstream
//  res_valid    out  1      result available
//  res_ready    in   1      result consumer ready
//  res_ones     out  LEN_W  ones counted at adder output
//  res_len      out  LEN_W  echo of the accepted cfg_len
//  res_aborted  out  1      job ended by abort
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  Reset: state IDLE. Outputs start_ready=1, add_clr=1; all other outputs 0, including lane_mask and res_*.
//  Reset is honoured in any state. Mid-job reset discards the job and produces no res_valid.
//  States and transitions:
//   IDLE  -> LOAD on start_valid&start_ready. Latch cfg_len and cfg_mask; clear the ones counter.
//   LOAD  1 cycle: sng_load=1, add_clr=1. Next state RUN if L!=0, otherwise DONE (res_ones=0).
//   RUN   sng_en=1, add_clr=0. Down-counter loads L. Leave to DRAIN when the counter reaches 1 (L cycles total).
//   DRAIN 1 cycle: sng_en=0, add_clr=0. Captures the last adder output.
//   DONE  res_valid=1, add_clr=1. Hold all res_* stable until res_ready; then go to IDLE.
//  add_clr=1 in IDLE, LOAD and DONE; 0 in RUN and DRAIN.
//  Adder latency: add_out reflects inputs one cycle later.
//   Sampling uses sen_q (sng_en delayed one cycle): count add_out when sen_q=1.
//   This gives exactly L samples, covering the 2nd RUN cycle through DRAIN.
//  Ones counter is LEN_W wide and saturating (it cannot exceed L in normal use).
//  abort in RUN: go to DRAIN next cycle with sng_en=0, then DONE with res_aborted=1.
//   res_ones holds the samples taken so far, including the DRAIN sample.
//  abort in DRAIN: still go to DONE, with res_aborted=1. abort is ignored in IDLE, LOAD and DONE.
//  No bypass: the DONE->IDLE handshake and a new start cannot complete in the same cycle.
//   A new job is accepted one cycle after res_ready at the earliest.
//  start_valid while busy: ignored (start_ready=0). cfg_* may change freely after the handshake.
//  res_len and lane_mask stay at the job values until the next accepted job.
// STRUCTURE
//  Package unsadd_ctrl_pkg holds:
//   typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} run_state_e;
//   default LEN_W and N constants.
//  Sub-module sc_ones_cnt: saturating bit counter with ports clk, rst, clr, en, bit_in, cnt[LEN_W].
//  FSM, length down-counter and sen_q pipeline flop live in the top.
// TESTING
//  L=8, mask=16'hFFFF, add_out tied 1 -> sng_load 1 cycle; sng_en high 8 cycles; res_ones=8, res_len=8, aborted=0.
//  L=0 -> sng_en never high; res_valid 2 cycles after handshake; res_ones=0.
//  L=4, res_ready held low 5 cycles -> res_valid stays high; res_* stable; start_ready=0; IDLE 1 cycle after res_ready.
//  rst pulsed at RUN cycle 3 of L=10 -> next cycle IDLE: add_clr=1, sng_en=0, no res_valid ever.
//  L=10, add_out=1, abort at RUN cycle 4 -> DRAIN then DONE; res_aborted=1; res_ones=4.
//  L=4095, add_out toggling starting at 1 on first sampled cycle -> res_ones=2048; no counter wrap.

Source files
------------

// File: rtl/unsadd_ctrl_pkg.sv
// Shared types and default sizes for the uNSADD16 run controller.
// No logic; types and constants only.
// Not applicable (no handshakes).
package unsadd_ctrl_pkg;

    localparam int N_DEF     = 16;
    localparam int LEN_W_DEF = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } run_state_e;

endpackage

// File: rtl/sc_ones_cnt.sv
// Saturating counter of ones on a sampled bitstream.
// Count visible one cycle after the sampled bit.
// No backpressure; clr has priority over counting.
module sc_ones_cnt #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         bit_in,
    output logic [W-1:0] cnt
);

    // Count ones while enabled, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && bit_in && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/unsadd_run_ctrl.sv
// Job sequencer for one uNSADD16 adder: load SNGs, stream L cycles, count L output samples.
// Result appears L+3 cycles after the start handshake (2 cycles for L=0).
// One job at a time; result held in DONE until res_ready, start_ready only in IDLE.
module unsadd_run_ctrl
    import unsadd_ctrl_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [N-1:0]     cfg_mask,
    input  logic             abort,
    output logic             sng_load,
    output logic             sng_en,
    output logic [N-1:0]     lane_mask,
    output logic             add_clr,
    input  logic             add_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [LEN_W-1:0] res_ones,
    output logic [LEN_W-1:0] res_len,
    output logic             res_aborted,
    output logic             busy
);

    run_state_e       state, state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_cnt;
    logic [N-1:0]     mask_q;
    logic             sen_q;
    logic             aborted_q;
    logic             add_clr_q;
    logic             start_hs;

    assign start_hs    = (state == IDLE) && start_valid;
    assign lane_mask   = mask_q;
    assign res_len     = len_q;
    assign res_aborted = aborted_q;
    assign add_clr     = add_clr_q;
    assign busy        = (state != IDLE);

    // Next-state and Moore outputs of the job sequencer.
    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        sng_load    = 1'b0;
        sng_en      = 1'b0;
        res_valid   = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_nxt = LOAD;
            end
            LOAD: begin
                sng_load  = 1'b1;
                state_nxt = (len_q == '0) ? DONE : RUN;
            end
            RUN: begin
                sng_en = 1'b1;
                if (abort || (len_cnt == LEN_W'(1))) state_nxt = DRAIN;
            end
            DRAIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, job registers, length down-counter and the adder-latency sample flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            mask_q    <= '0;
            len_cnt   <= '0;
            sen_q     <= 1'b0;
            aborted_q <= 1'b0;
            add_clr_q <= 1'b1;
        end else begin
            state <= state_nxt;
            sen_q <= sng_en;
            // Adder is held cleared whenever the next state is not streaming.
            add_clr_q <= (state_nxt == IDLE) || (state_nxt == LOAD) || (state_nxt == DONE);
            if (start_hs) begin
                len_q     <= cfg_len;
                mask_q    <= cfg_mask;
                aborted_q <= 1'b0;
            end
            if (state == LOAD) begin
                len_cnt <= len_q;
            end else if (state == RUN) begin
                len_cnt <= len_cnt - LEN_W'(1);
            end
            if (((state == RUN) || (state == DRAIN)) && abort) begin
                aborted_q <= 1'b1;
            end
        end
    end

    // add_out lags sng_en by one cycle, so samples are taken while sen_q is high.
    sc_ones_cnt #(.W(LEN_W)) u_ones (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_hs),
        .en     (sen_q),
        .bit_in (add_out),
        .cnt    (res_ones)
    );

endmodule

// File: tb/tb_unsadd_run_ctrl.sv
// Self-checking bench for unsadd_run_ctrl: directed table, hand sequences, random jobs.
// Expected results come from a per-cycle add_out schedule and the job timing rules.
// Bench drives and samples on the falling edge; DUT acts on the rising edge.
module tb_unsadd_run_ctrl;

    localparam int N     = 16;
    localparam int LEN_W = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_valid;
    logic             start_ready;
    logic [LEN_W-1:0] cfg_len;
    logic [N-1:0]     cfg_mask;
    logic             abort;
    logic             sng_load;
    logic             sng_en;
    logic [N-1:0]     lane_mask;
    logic             add_clr;
    logic             add_out;
    logic             res_valid;
    logic             res_ready;
    logic [LEN_W-1:0] res_ones;
    logic [LEN_W-1:0] res_len;
    logic             res_aborted;
    logic             busy;

    int tests = 0;
    int fails = 0;

    // add_out value to drive during cycle c after the start handshake (c=1 is LOAD).
    bit add_seq [0:4299];

    typedef struct {
        int          len;
        logic [15:0] mask;
        int          abort_k;   // 0: no abort; k: abort during RUN cycle k (k=len+1 hits DRAIN)
        int          rdy_dly;   // cycles res_ready held low in DONE
        int          pat;       // 0 all ones, 1 toggling from 1, 2 random
        int          exp_ones;  // -1: take from the schedule model
        int          exp_ab;    // -1: take from the schedule model
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    unsadd_run_ctrl #(.N(N), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .cfg_len     (cfg_len),
        .cfg_mask    (cfg_mask),
        .abort       (abort),
        .sng_load    (sng_load),
        .sng_en      (sng_en),
        .lane_mask   (lane_mask),
        .add_clr     (add_clr),
        .add_out     (add_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_ones    (res_ones),
        .res_len     (res_len),
        .res_aborted (res_aborted),
        .busy        (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One complete job: handshake, stream, result, delayed result handshake.
    task automatic run_job(input string tag, input vec_t v);
        int  nrun, exp_ones, exp_vc, vc, sl, se, clr_lo, exp_ab;
        int  hold_ones;
        bit  seen;
        for (int i = 0; i < 4300; i++) begin
            case (v.pat)
                0:       add_seq[i] = 1'b1;
                1:       add_seq[i] = (i % 2) == 1;   // cycle 3, first sample, gets a 1
                default: add_seq[i] = 1'($urandom_range(0, 1));
            endcase
        end
        // Samples cover the cycles after the first RUN cycle through DRAIN.
        if (v.len == 0)                             nrun = 0;
        else if (v.abort_k > 0 && v.abort_k < v.len) nrun = v.abort_k;
        else                                        nrun = v.len;
        exp_ones = 0;
        for (int c = 3; c <= nrun + 2; c++) exp_ones += int'(add_seq[c]);
        exp_ab = (v.len > 0 && v.abort_k > 0 && v.abort_k <= v.len + 1) ? 1 : 0;
        if (v.exp_ones >= 0) exp_ones = v.exp_ones;
        if (v.exp_ab >= 0)   exp_ab   = v.exp_ab;
        exp_vc = (v.len == 0) ? 2 : nrun + 3;

        @(negedge clk);
        start_valid = 1'b1;
        cfg_len     = LEN_W'(v.len);
        cfg_mask    = v.mask;
        res_ready   = 1'b0;
        chk({tag, " start_ready"}, int'(start_ready), 1);
        @(posedge clk);
        vc = 0; sl = 0; se = 0; clr_lo = 0; seen = 0;
        for (int c = 1; c < 4400 && !seen; c++) begin
            @(negedge clk);
            start_valid = 1'b0;
            cfg_len     = LEN_W'($urandom);
            cfg_mask    = N'($urandom);
            add_out     = add_seq[c];
            abort       = (v.len > 0 && v.abort_k > 0 && c == v.abort_k + 1);
            sl     += int'(sng_load);
            se     += int'(sng_en);
            clr_lo += int'(!add_clr);
            if (res_valid) begin
                seen = 1;
                vc   = c;
            end
        end
        abort = 1'b0;
        chk({tag, " res_valid arrival cycle"}, vc, exp_vc);
        chk({tag, " sng_load cycles"}, sl, 1);
        chk({tag, " sng_en cycles"}, se, nrun);
        chk({tag, " add_clr low cycles"}, clr_lo, (v.len == 0) ? 0 : nrun + 1);
        chk({tag, " res_ones"}, int'(res_ones), exp_ones);
        chk({tag, " res_len"}, int'(res_len), v.len);
        chk({tag, " res_aborted"}, int'(res_aborted), exp_ab);
        chk({tag, " lane_mask"}, int'(lane_mask), int'(v.mask));
        hold_ones = int'(res_ones);
        for (int d = 0; d < v.rdy_dly; d++) begin
            @(negedge clk);
            chk({tag, " hold res_valid"}, int'(res_valid), 1);
            chk({tag, " hold res_ones"}, int'(res_ones), hold_ones);
            chk({tag, " hold start_ready"}, int'(start_ready), 0);
        end
        // start_valid rides along with res_ready: it must not be accepted on this edge.
        res_ready   = 1'b1;
        start_valid = 1'b1;
        @(negedge clk);
        res_ready   = 1'b0;
        start_valid = 1'b0;
        chk({tag, " idle after res_ready"}, int'(busy), 0);
        chk({tag, " start_ready after res_ready"}, int'(start_ready), 1);
        chk({tag, " res_valid dropped"}, int'(res_valid), 0);
        chk({tag, " res_len kept"}, int'(res_len), v.len);
        chk({tag, " add_clr in idle"}, int'(add_clr), 1);
    endtask

    initial begin
        int seen_valid;
        vecs[0] = '{len: 8,    mask: 16'hFFFF, abort_k: 0, rdy_dly: 0, pat: 0, exp_ones: 8,    exp_ab: 0};
        vecs[1] = '{len: 0,    mask: 16'h00F0, abort_k: 0, rdy_dly: 0, pat: 0, exp_ones: 0,    exp_ab: 0};
        vecs[2] = '{len: 4,    mask: 16'h1234, abort_k: 0, rdy_dly: 5, pat: 0, exp_ones: 4,    exp_ab: 0};
        vecs[3] = '{len: 10,   mask: 16'hA5A5, abort_k: 4, rdy_dly: 1, pat: 0, exp_ones: 4,    exp_ab: 1};
        vecs[4] = '{len: 5,    mask: 16'h0001, abort_k: 6, rdy_dly: 0, pat: 0, exp_ones: 5,    exp_ab: 1};
        vecs[5] = '{len: 1,    mask: 16'h8000, abort_k: 0, rdy_dly: 2, pat: 0, exp_ones: 1,    exp_ab: 0};
        vecs[6] = '{len: 4095, mask: 16'hFFFF, abort_k: 0, rdy_dly: 0, pat: 1, exp_ones: 2048, exp_ab: 0};

        rst = 1'b1; start_valid = 1'b0; cfg_len = '0; cfg_mask = '0;
        abort = 1'b0; add_out = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset start_ready", int'(start_ready), 1);
        chk("reset add_clr", int'(add_clr), 1);
        chk("reset sng_en", int'(sng_en), 0);
        chk("reset sng_load", int'(sng_load), 0);
        chk("reset lane_mask", int'(lane_mask), 0);
        chk("reset res_valid", int'(res_valid), 0);
        chk("reset res_ones", int'(res_ones), 0);
        chk("reset res_len", int'(res_len), 0);
        chk("reset res_aborted", int'(res_aborted), 0);
        chk("reset busy", int'(busy), 0);

        for (int i = 0; i < 7; i++) run_job($sformatf("vec%0d", i), vecs[i]);

        // Reset during RUN cycle 3 of an L=10 job.
        @(negedge clk);
        start_valid = 1'b1; cfg_len = 12'd10; cfg_mask = 16'h0F0F; add_out = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start_valid = 1'b0;
        end
        chk("midrst in RUN", int'(sng_en), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst add_clr", int'(add_clr), 1);
        chk("midrst sng_en", int'(sng_en), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst start_ready", int'(start_ready), 1);
        seen_valid = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            seen_valid += int'(res_valid);
        end
        chk("midrst no res_valid", seen_valid, 0);

        // Random jobs: random add_out, length, mask, optional abort, result delay.
        for (int j = 0; j < 30; j++) begin
            vec_t v;
            v.len      = int'($urandom_range(0, 40));
            v.mask     = 16'($urandom);
            v.abort_k  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, v.len + 1)) : 0;
            v.rdy_dly  = int'($urandom_range(0, 3));
            v.pat      = 2;
            v.exp_ones = -1;
            v.exp_ab   = -1;
            run_job($sformatf("rnd%0d", j), v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
